// File: rtl/axi_stream_packet_split_pkg.sv
// Shared AXI-Stream definitions for the packet splitter slice: the fragment
// tag carried to the packet FIFO, its width, and the splitter state type.
package axi_stream_packet_split_pkg;

    // Byte-count width used by the downstream packet FIFO.
    localparam int PKT_FIFO_LEN_W = 16;

    // Fragment index width and total tag width {frag_first, frag_final, frag_idx}.
    localparam int FRAG_IDX_W = 8;
    localparam int FRAG_TAG_W = FRAG_IDX_W + 2;

    typedef struct packed {
        logic                  frag_first;
        logic                  frag_final;
        logic [FRAG_IDX_W-1:0] frag_idx;
    } frag_tag_t;

    // Splitter packet tracking: waiting for a first beat, or inside a packet.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } split_state_t;

endpackage

// File: rtl/axi_stream_packet_split_pipe_reg.sv
// Single-entry AXI-Stream register slice. Ready is combinational from the
// downstream side so a full slice still accepts a beat in the cycle it drains,
// giving one beat per clock. Payload is opaque and held while stalled.
module axis_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic load;

    assign s_ready = !m_valid || m_ready;
    assign load    = s_valid && s_ready;

    // Load on input handshake; drop valid only when drained with nothing new.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_stream_packet_split.sv
// AXI-Stream packet splitter. Cuts each input packet into fragments of at most
// len_q beats (len_q latched from max_len on a packet's first beat, 0 = no
// split) and tags each fragment with {frag_first, frag_final, frag_idx} for
// the downstream packet FIFO. Output is one registered stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | next accepted beat is the first beat of a packet; max_len
//           | is used directly and latched into len_q on that beat
//   ST_PKT  | inside a packet; len_q governs fragment boundaries
module axi_stream_packet_split
    import axi_stream_packet_split_pkg::*;
#(
    parameter int DSIZE = 24,
    parameter int LSIZE = PKT_FIFO_LEN_W,
    parameter int ISIZE = FRAG_IDX_W
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [LSIZE-1:0] max_len,

    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [DSIZE-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,

    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tlast,

    output logic [ISIZE+1:0] out_cdata
);

    localparam int              PW      = ISIZE + 2 + 1 + DSIZE;
    localparam logic [ISIZE-1:0] IDX_MAX = '1;

    split_state_t     state;
    split_state_t     state_nxt;

    logic [LSIZE-1:0] len_q;
    logic [LSIZE-1:0] len_eff;
    logic [LSIZE-1:0] len_m1;
    logic [LSIZE-1:0] beat_cnt;
    logic [ISIZE-1:0] frag_idx;

    logic             s_load;
    logic             len_hit;
    logic             frag_end;
    logic             frag_first;
    logic             frag_final;

    logic [PW-1:0]    pipe_in;
    logic [PW-1:0]    pipe_out;

    assign s_load = s_axis_tvalid && s_axis_tready;

    // Packet tracking state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Enter ST_PKT on any non-last beat, return to ST_IDLE on the input tlast.
    always_comb begin
        state_nxt = state;
        if (s_load) begin
            state_nxt = s_axis_tlast ? ST_IDLE : ST_PKT;
        end
    end

    // Fragment boundary and tag for the beat currently offered upstream.
    // On a first beat len_q is not yet loaded, so max_len is used directly.
    always_comb begin
        len_eff    = (state == ST_IDLE) ? max_len : len_q;
        len_m1     = len_eff - LSIZE'(1);
        len_hit    = (len_eff != '0) && (beat_cnt == len_m1);
        frag_end   = s_axis_tlast || len_hit;
        frag_first = (frag_idx == '0);
        frag_final = (len_eff == '0) ? 1'b1 : s_axis_tlast;
    end

    // Latch the length limit on the first accepted beat of each packet.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            len_q <= '0;
        end else if (s_load && (state == ST_IDLE)) begin
            len_q <= max_len;
        end
    end

    // Beat counter within a fragment and saturating fragment index.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            frag_idx <= '0;
        end else if (s_load) begin
            if (frag_end) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + LSIZE'(1);
            end

            if (s_axis_tlast) begin
                frag_idx <= '0;
            end else if (len_hit && (frag_idx != IDX_MAX)) begin
                frag_idx <= frag_idx + ISIZE'(1);
            end
        end
    end

    assign pipe_in = {frag_first, frag_final, frag_idx, frag_end, s_axis_tdata};

    axis_pipe_reg #(
        .WIDTH (PW)
    ) u_pipe (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  (pipe_in),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (pipe_out)
    );

    assign {out_cdata, m_axis_tlast, m_axis_tdata} = pipe_out;

endmodule

// File: tb/tb_axi_stream_packet_split.sv
// Bench for axi_stream_packet_split: table of directed packets, a reset
// mid-packet sequence, and randomized packets under backpressure, all checked
// beat-by-beat against a fragment model computed from packet position.
module tb_axi_stream_packet_split;
    import axi_stream_packet_split_pkg::*;

    localparam int DSIZE = 24;
    localparam int LSIZE = 16;
    localparam int ISIZE = 8;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [LSIZE-1:0] max_len;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [DSIZE-1:0] s_axis_tdata;
    logic             s_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [DSIZE-1:0] m_axis_tdata;
    logic             m_axis_tlast;
    logic [ISIZE+1:0] out_cdata;

    axi_stream_packet_split #(
        .DSIZE (DSIZE),
        .LSIZE (LSIZE),
        .ISIZE (ISIZE)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .max_len       (max_len),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .out_cdata     (out_cdata)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [DSIZE-1:0] data;
        logic             last;
        logic [ISIZE+1:0] cdata;
    } exp_t;

    typedef struct {
        int n;
        int ml;
        int chg;
        int nml;
        int frags;
        int first_len;
        int last_len;
    } vec_t;

    exp_t    exp_q[$];
    int      frag_lens[$];
    int      cur_len;
    int      pass_cnt  = 0;
    int      total_cnt = 0;
    int      in_beats, out_beats;
    longint  in_sum, out_sum;
    bit      bp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Downstream ready: always 1, or a 50% coin flip per cycle.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: compares accepted beats with the model queue and checks
    // that a stalled beat is held unchanged into the next cycle.
    initial begin
        logic        stall_prev;
        logic [63:0] stall_snap;
        exp_t        e;
        stall_prev = 1'b0;
        stall_snap = '0;
        cur_len    = 0;
        out_beats  = 0;
        out_sum    = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev)
                chk("stall_hold", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, out_cdata}), stall_snap);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    if (e.last) chk("frag_tag", 64'(out_cdata), 64'(e.cdata));
                end
                out_beats++;
                out_sum += longint'(m_axis_tdata);
                cur_len++;
                if (m_axis_tlast) begin
                    frag_lens.push_back(cur_len);
                    cur_len = 0;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_snap = 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, out_cdata});
        end
    end

    // Sends beats 0..n-1 (stopping early at stop_at if >= 0). max_len is set to
    // ml for the first beat and to nml from beat chg on. The expected output
    // for each accepted beat is derived from its position in the packet.
    task automatic send_pkt(input int n, input int ml, input int chg, input int nml,
                            input bit gaps, input int stop_at, output int stalls);
        int        waits;
        bit        acc;
        int        f;
        exp_t      e;
        frag_tag_t t;
        stalls  = 0;
        max_len = LSIZE'(ml);
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) break;
            if (i == chg) max_len = LSIZE'(nml);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge aclk);
                    #1;
                end
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DSIZE'($urandom);
            s_axis_tlast  = (i == n - 1);
            waits = 0;
            forever begin
                @(negedge aclk);
                acc = s_axis_tready;
                @(posedge aclk);
                #1;
                if (acc) break;
                stalls++;
                waits++;
                if (waits > 5000) begin
                    chk("accept_timeout", 64'(waits), 64'(0));
                    break;
                end
            end
            if (i == 0) chk("latency_1", 64'(m_axis_tvalid), 64'(1));
            f            = (ml == 0) ? 0 : i / ml;
            t.frag_idx   = (f > 255) ? 8'hFF : 8'(f);
            t.frag_first = (f == 0);
            t.frag_final = (i == n - 1);
            e.data       = s_axis_tdata;
            e.last       = (i == n - 1) || ((ml != 0) && ((i % ml) == ml - 1));
            e.cdata      = t;
            exp_q.push_back(e);
            in_beats++;
            in_sum += longint'(s_axis_tdata);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && c < 5000) begin
            @(negedge aclk);
            c++;
        end
        chk("drain_done", 64'(c < 5000), 64'(1));
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   stalls;
        int   n, ml;

        vecs[0] = '{n: 10,  ml: 4, chg: -1, nml: 0, frags: 3,   first_len: 4,   last_len: 2};
        vecs[1] = '{n: 8,   ml: 4, chg: -1, nml: 0, frags: 2,   first_len: 4,   last_len: 4};
        vecs[2] = '{n: 300, ml: 0, chg: -1, nml: 0, frags: 1,   first_len: 300, last_len: 300};
        vecs[3] = '{n: 7,   ml: 3, chg: 2,  nml: 2, frags: 3,   first_len: 3,   last_len: 1};
        vecs[4] = '{n: 5,   ml: 2, chg: -1, nml: 0, frags: 3,   first_len: 2,   last_len: 1};
        vecs[5] = '{n: 1,   ml: 4, chg: -1, nml: 0, frags: 1,   first_len: 1,   last_len: 1};
        vecs[6] = '{n: 300, ml: 1, chg: -1, nml: 0, frags: 300, first_len: 1,   last_len: 1};
        vecs[7] = '{n: 5,   ml: 5, chg: -1, nml: 0, frags: 1,   first_len: 5,   last_len: 5};

        in_beats      = 0;
        in_sum        = 0;
        aresetn       = 1'b0;
        max_len       = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_m_tlast",  64'(m_axis_tlast),  64'(0));
        chk("rst_m_tdata",  64'(m_axis_tdata),  64'(0));
        chk("rst_cdata",    64'(out_cdata),     64'(0));
        aresetn = 1'b1;
        chk("rst_s_tready", 64'(s_axis_tready), 64'(1));

        foreach (vecs[v]) begin
            frag_lens.delete();
            cur_len = 0;
            send_pkt(vecs[v].n, vecs[v].ml, vecs[v].chg, vecs[v].nml, 1'b0, -1, stalls);
            wait_drain();
            chk($sformatf("v%0d_full_rate", v), 64'(stalls), 64'(0));
            chk($sformatf("v%0d_frag_count", v), 64'(frag_lens.size()), 64'(vecs[v].frags));
            if (frag_lens.size() > 0) begin
                chk($sformatf("v%0d_first_len", v), 64'(frag_lens[0]), 64'(vecs[v].first_len));
                chk($sformatf("v%0d_last_len", v), 64'(frag_lens[$]), 64'(vecs[v].last_len));
            end
        end

        // Reset after beat 5 of a 10-beat packet, then a clean 6-beat packet.
        send_pkt(10, 4, -1, 0, 1'b0, 5, stalls);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("midrst_s_tready", 64'(s_axis_tready), 64'(1));
        exp_q.delete();
        frag_lens.delete();
        cur_len = 0;
        send_pkt(6, 4, -1, 0, 1'b0, -1, stalls);
        wait_drain();
        chk("midrst_frag_count", 64'(frag_lens.size()), 64'(2));
        if (frag_lens.size() == 2) begin
            chk("midrst_len0", 64'(frag_lens[0]), 64'(4));
            chk("midrst_len1", 64'(frag_lens[1]), 64'(2));
        end

        // Randomized packets with input gaps and 50% downstream backpressure.
        in_beats  = 0;
        in_sum    = 0;
        out_beats = 0;
        out_sum   = 0;
        bp_en     = 1'b1;
        for (int p = 0; p < 20; p++) begin
            n  = $urandom_range(1, 40);
            ml = $urandom_range(0, 6);
            send_pkt(n, ml, $urandom_range(1, n), $urandom_range(0, 6), 1'b1, -1, stalls);
        end
        wait_drain();
        bp_en = 1'b0;
        chk("rand_beat_total", 64'(out_beats), 64'(in_beats));
        chk("rand_checksum",   64'(out_sum),   64'(in_sum));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axi_stream_packet_split.md
AXI_STREAM_PACKET_SPLIT -- requirements
Module: axi_stream_packet_split

Interface
REQ-001 Parameter DSIZE, default 24: data width in bits.
REQ-002 Parameter LSIZE, default 16: width of the length limit and beat counter.
REQ-003 Parameter ISIZE, default 8: width of the fragment index.
REQ-004 aclk  input  1  single clock; all logic samples on its rising edge.
REQ-005 aresetn  input  1  synchronous active-low reset.
REQ-006 max_len  input  LSIZE  maximum beats per output fragment; 0 = no splitting.
REQ-007 s_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DSIZE/1  upstream stream.
REQ-008 m_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DSIZE/1  downstream stream; feeds a packet FIFO.
REQ-009 out_cdata  output  ISIZE+2  {frag_first, frag_final, frag_idx}; valid while m_axis_tvalid is high, and meaningful on the tlast beat (the packet FIFO samples it there).

Function
REQ-010 The block shall split each input packet into fragments of at most max_len beats, forcing m_axis_tlast on each fragment's final beat.
REQ-011 Data, beat order and beat count shall be preserved exactly; no beat is dropped or duplicated.
REQ-012 max_len shall be latched as len_q when the first beat of an input packet is accepted; changes mid-packet shall have no effect until the next packet.
REQ-013 If len_q == 0, packets shall pass unsplit: m_tlast = s_tlast, frag_idx = 0, frag_first = frag_final = 1.
REQ-014 A beat counter beat_cnt (LSIZE bits) shall count beats accepted in the current fragment.
  - It resets to 0 after a fragment-ending beat.
  - A beat ends a fragment when beat_cnt == len_q-1 or s_tlast = 1.
REQ-015 frag_idx (ISIZE bits) shall increment per fragment and clear on an input tlast.
  - It saturates at all-ones and does not wrap.
REQ-016 frag_first shall be 1 for fragment 0; frag_final shall be 1 only for the fragment containing the input tlast.
REQ-017 If the input tlast coincides with a length boundary, exactly one fragment shall end there, with frag_final = 1; no empty fragment is generated.
REQ-018 The output shall be a single registered stage with latency 1 cycle from s accept to m_valid.
REQ-019 Handshake for that stage:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - The stage loads on s_tvalid && s_tready.
  - m_tvalid clears only when m_tready is high and no new beat loads.
REQ-020 While m_tvalid = 1 and m_tready = 0, m_tdata, m_tlast and out_cdata shall hold stable.
REQ-021 Simultaneous output accept and input load shall sustain one beat per cycle, giving full throughput.
REQ-022 A single-beat packet shall produce one beat with tlast = 1, frag_first = 1, frag_final = 1, idx = 0.

Reset
REQ-023 While aresetn = 0 at a clock edge:
  - m_axis_tvalid, m_axis_tlast and out_cdata go to 0.
  - m_axis_tdata goes to 0.
  - beat_cnt, frag_idx and len_q go to 0.
  - The in-packet flag clears.
REQ-024 A reset mid-packet shall discard the partial packet state; the next accepted beat is treated as the first beat of a new packet.
REQ-025 s_axis_tready shall be 1 in the first cycle after reset release.

Structure
REQ-026 The fragment tag struct {frag_first, frag_final, frag_idx} and its width constant shall live in the shared axi_stream package.
REQ-027 The split counting logic shall be in this module.
REQ-028 The output register stage shall be one sub-module, axis_pipe_reg, which is reusable elsewhere.
REQ-029 LSIZE shall match the packet FIFO byte-count width (16).

Verification
REQ-030 max_len=4, one 10-beat packet, m_tready=1 -> fragments of 4, 4, 2 beats.
  - idx = 0, 1, 2; first = 1, 0, 0; final = 0, 0, 1.
  - Data matches input order.
REQ-031 max_len=4, one 8-beat packet -> exactly two fragments of 4 beats each.
  - The second fragment has final = 1.
  - No zero-length fragment.
REQ-032 max_len=0, one 300-beat packet -> one 300-beat fragment with idx = 0.
REQ-033 max_len=3, a 7-beat packet with max_len changed to 2 at beat 2 -> fragments 3, 3, 1.
  - The following packet uses 2.
REQ-034 Random m_tready at 50% backpressure, 20 packets -> outputs stable while stalled.
  - Total beat count and data checksum match the input.
REQ-035 aresetn pulsed low at beat 5 of a 10-beat packet with max_len=4 -> m_tvalid = 0 the next cycle.
  - The next packet (6 beats) yields fragments 4, 2 with idx = 0, 1.
